// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port dmem between two requesters
// Grants are combinational; read data returns through a READ_LAT-deep tag pipeline.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_q,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic                ptr_q, ptr_d;
  logic                own_vld_q, own_vld_d;
  logic                own_q, own_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LAT-1:0] tag_port_q, tag_port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0]   p0_q_q, p0_q_d;
  logic [DATA_W-1:0]   p1_q_q, p1_q_d;

  logic                sel;
  logic                acc;
  logic                g_lock;
  logic                g_wren;
  logic                other_req;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic [CNT_W-1:0]    streak;
  logic [CNT_W-1:0]    streak_nxt;
  logic                tag_out_vld;
  logic                tag_out_port;

  // sel names the winning port; acc is held low while reset is asserted
  always_comb begin
    sel       = (p0_req && p1_req) ? ptr_q : p1_req;
    acc       = (p0_req || p1_req) && reset;
    g_lock    = sel ? p1_lock : p0_lock;
    g_wren    = sel ? p1_wren : p0_wren;
    g_addr    = sel ? p1_addr : p0_addr;
    g_data    = sel ? p1_data : p0_data;
    other_req = sel ? p0_req  : p1_req;
  end

  assign p0_gnt      = acc && !sel;
  assign p1_gnt      = acc && sel;
  assign mem_wren    = acc && g_wren;
  assign mem_address = acc ? g_addr : addr_q;
  assign mem_data    = acc ? g_data : data_q;

  // The streak only continues while the same port keeps winning with lock set
  always_comb begin
    streak     = (own_vld_q && (own_q == sel)) ? cnt_q : '0;
    streak_nxt = streak + CNT_W'(other_req);
    ptr_d      = ptr_q;
    own_vld_d  = 1'b0;
    own_d      = own_q;
    cnt_d      = '0;
    if (acc) begin
      if (g_lock) begin
        if (streak_nxt == CNT_W'(MAX_LOCK)) begin
          ptr_d = !sel;
        end else begin
          ptr_d     = sel;
          own_vld_d = 1'b1;
          own_d     = sel;
          cnt_d     = streak_nxt;
        end
      end else begin
        ptr_d = !sel;
      end
    end
  end

  always_comb begin
    addr_d        = mem_address;
    data_d        = mem_data;
    tag_vld_d     = '0;
    tag_port_d    = '0;
    tag_vld_d[0]  = acc && !g_wren;
    tag_port_d[0] = sel;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_port_d[i] = tag_port_q[i-1];
    end
    tag_out_vld  = tag_vld_q[READ_LAT-1];
    tag_out_port = tag_port_q[READ_LAT-1];
    p0_rvalid_d  = tag_out_vld && !tag_out_port;
    p1_rvalid_d  = tag_out_vld && tag_out_port;
    p0_q_d       = p0_rvalid_d ? mem_q : p0_q_q;
    p1_q_d       = p1_rvalid_d ? mem_q : p1_q_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q       <= 1'b0;
      own_vld_q   <= 1'b0;
      own_q       <= 1'b0;
      cnt_q       <= '0;
      tag_vld_q   <= '0;
      tag_port_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_q_q      <= '0;
      p1_q_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      own_vld_q   <= own_vld_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_port_q  <= tag_port_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_q_q      <= p0_q_d;
      p1_q_q      <= p1_q_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_q      = p0_q_q;
  assign p1_q      = p1_q_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Includes a behavioural dmem and an arbitration/return-order reference model.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int L  = 1;
  localparam int ML = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req, p0_wren, p0_lock, p1_req, p1_wren, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr, mem_address;
  logic [DW-1:0] p0_data, p1_data, mem_data, mem_q, p0_q, p1_q;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wren;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L), .MAX_LOCK(ML)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_data(p0_data),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_q(p0_q),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_data(p1_data),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_q(p1_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // behavioural single-port dmem with L cycles of read latency
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rd_pipe [0:L-1];
  assign mem_q = rd_pipe[L-1];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    rd_pipe[0] <= mem[mem_address];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  function automatic logic [DW-1:0] init_val(int a);
    return 32'hA500_0000 ^ a;
  endfunction

  // reference model state
  typedef struct { int due; int port; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] shadow [int];
  int            m_fav, m_owner, m_streak, cyc, model_g;
  logic [DW-1:0] m_q [2];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          seen_g0, seen_g1;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] shadow_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fav = 0; m_owner = -1; m_streak = 0;
    m_q[0] = '0; m_q[1] = '0; m_addr = '0; m_data = '0;
    rq.delete();
  endtask

  // one cycle: drive at negedge, check grant side, step the model, check returns at next negedge
  task automatic apply(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int g, other;
    logic oreq, glock, gw, e0, e1;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    p0_req = r0; p0_wren = w0; p0_lock = l0; p0_addr = a0; p0_data = d0;
    p1_req = r1; p1_wren = w1; p1_lock = l1; p1_addr = a1; p1_data = d1;
    #1;
    if (r0 && r1) g = m_fav; else if (r0) g = 0; else if (r1) g = 1; else g = -1;
    model_g = g; seen_g0 = p0_gnt; seen_g1 = p1_gnt;
    chk("p0_gnt", p0_gnt, g == 0);
    chk("p1_gnt", p1_gnt, g == 1);
    gw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    chk("mem_wren", mem_wren, gw);
    if (g >= 0) begin
      ga = g ? a1 : a0; gd = g ? d1 : d0;
      m_addr = ga; m_data = gd;
      other = 1 - g;
      oreq  = other ? r1 : r0;
      glock = g ? l1 : l0;
      if (gw) shadow[int'(ga)] = gd;
      else rq.push_back('{cyc + L + 1, g, shadow_rd(int'(ga))});
      if (glock) begin
        if (m_owner != g) begin m_owner = g; m_streak = 0; end
        m_streak += int'(oreq);
        m_fav = g;
        if (m_streak == ML) begin m_fav = other; m_owner = -1; m_streak = 0; end
      end else begin
        m_fav = other; m_owner = -1; m_streak = 0;
      end
    end else begin
      m_owner = -1; m_streak = 0;
    end
    chk("mem_address", mem_address, m_addr);
    chk("mem_data", mem_data, m_data);
    @(negedge clock);
    cyc++;
    e0 = 1'b0; e1 = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].port == 0) e0 = 1'b1; else e1 = 1'b1;
      m_q[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("p0_rvalid", p0_rvalid, e0);
    chk("p1_rvalid", p1_rvalid, e1);
    chk("p0_q", p0_q, m_q[0]);
    chk("p1_q", p1_q, m_q[1]);
  endtask

  task automatic idle();
    apply(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // asserts reset at a negedge; with busy set, requests are driven to prove grants are gated
  task automatic do_reset(input logic busy);
    p0_req = busy; p0_wren = busy; p0_lock = 0; p1_req = busy; p1_wren = busy; p1_lock = 0;
    reset = 1'b0;
    #1;
    chk("rst_p0_gnt", p0_gnt, 1'b0);
    chk("rst_p1_gnt", p1_gnt, 1'b0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_p0_rvalid", p0_rvalid, 1'b0);
    chk("rst_p1_rvalid", p1_rvalid, 1'b0);
    chk("rst_p0_q", p0_q, '0);
    chk("rst_p1_q", p1_q, '0);
    @(negedge clock);
    p0_req = 0; p0_wren = 0; p1_req = 0; p1_wren = 0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct { logic r0, r1, l0, l1, g0, g1; } vec_t;
  vec_t vecs[12];

  typedef struct { logic pend, w, l; logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  req_t rp[2];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    mem[12'h010] = 32'hDEAD_BEEF;
    shadow[16] = 32'hDEAD_BEEF;
    cyc = 0;
    model_reset();
    do_reset(1'b0);

    // single read with known contents
    apply(1, 0, 0, 12'h010, '0, 0, 0, 0, '0, '0);
    chk("t1_gnt", seen_g0, 1'b1);
    repeat (L) idle();
    chk("t1_rvalid", p0_rvalid, 1'b1);
    chk("t1_q", p0_q, 32'hDEAD_BEEF);
    chk("t1_p1_rvalid", p1_rvalid, 1'b0);

    // write by port 1 then read-back by port 0 on the next cycle
    apply(0, 0, 0, '0, '0, 1, 1, 0, 12'h020, 32'h1234_5678);
    chk("t2_wgnt", seen_g1, 1'b1);
    apply(1, 0, 0, 12'h020, '0, 0, 0, 0, '0, '0);
    repeat (L) idle();
    chk("t2_rvalid", p0_rvalid, 1'b1);
    chk("t2_q", p0_q, 32'h1234_5678);

    // arbitration table from a fresh reset (pointer on port 0)
    vecs = '{'{1,0,0,0,1,0}, '{1,1,0,0,0,1}, '{1,1,0,0,1,0}, '{0,0,0,0,0,0},
             '{1,1,0,0,0,1}, '{0,1,0,0,0,1}, '{1,1,0,0,1,0}, '{1,1,1,0,0,1},
             '{1,1,1,0,1,0}, '{1,1,1,0,1,0}, '{1,1,0,0,1,0}, '{1,1,0,0,0,1}};
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].r0, 0, vecs[i].l0, AW'(12'h100 + i), '0,
            vecs[i].r1, 0, vecs[i].l1, AW'(12'h200 + i), '0);
      chk($sformatf("vec%0d_g0", i), seen_g0, vecs[i].g0);
      chk($sformatf("vec%0d_g1", i), seen_g1, vecs[i].g1);
    end
    repeat (L + 1) idle();

    // port 1 locks for 20 cycles against a waiting port 0: bursts of 8
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      apply(1, 0, 0, AW'(i), '0, 1, 0, 1, AW'(12'h40 + i), '0);
      chk($sformatf("lock%0d_g1", i), seen_g1, (i != 0) && ((i - 1) % 9 != 8));
    end
    repeat (L + 1) idle();

    // lone locking requester keeps the grant and accumulates no streak
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 0, '0, '0, 1, 1, 1, AW'(12'h300 + i), $urandom);
      chk($sformatf("solo%0d_g1", i), seen_g1, 1'b1);
    end
    for (int j = 0; j < 10; j++) begin
      apply(1, 0, 0, AW'(j), '0, 1, 0, 1, AW'(12'h300 + j), '0);
      chk($sformatf("solo_then%0d_g1", j), seen_g1, j != 8);
    end
    repeat (L + 1) idle();

    // reset while a read is in flight
    do_reset(1'b0);
    apply(0, 0, 0, '0, '0, 1, 0, 0, 12'h010, '0);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t5_p0_rvalid", p0_rvalid, 1'b0);
      chk("t5_p1_rvalid", p1_rvalid, 1'b0);
    end
    apply(1, 0, 0, 12'h005, '0, 1, 0, 0, 12'h006, '0);
    chk("t5_ptr_port0", seen_g0, 1'b1);
    repeat (L + 1) idle();

    // randomized traffic; a requester holds its request until granted
    do_reset(1'b0);
    rp[0].pend = 0; rp[1].pend = 0;
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rp[p].pend) begin
          rp[p].pend = ($urandom_range(0, 99) < 65);
          rp[p].w    = $urandom_range(0, 2) == 0;
          rp[p].l    = $urandom_range(0, 3) == 0;
          rp[p].a    = AW'($urandom_range(0, 15));
          rp[p].d    = $urandom;
        end
      end
      apply(rp[0].pend, rp[0].w, rp[0].l, rp[0].a, rp[0].d,
            rp[1].pend, rp[1].w, rp[1].l, rp[1].a, rp[1].d);
      if (model_g >= 0) rp[model_g].pend = 0;
    end
    repeat (L + 2) idle();
    chk("rand_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem between two requesters: port 0 (processor) and port 1 (test/boot loader that preloads or inspects data memory).
- Sits between the requesters and the dmem instance. Drives dmem address, data and wren, and routes dmem q back to the port that issued the read.
- Arbitration is round-robin, with an optional bounded lock that lets one port perform back-to-back bursts.
- Fully pipelined: one accepted access per cycle.

Parameters:
- ADDR_W, 12, address width (matches dmem depth of 4096 words).
- DATA_W, 32, data word width.
- READ_LAT, 1, cycles from accepted read to q valid at the dmem output (1..3).
- MAX_LOCK, 8, maximum consecutive grants a locking port may hold while the other port is waiting.

Ports:
- clock  in  1  block clock; same edge as dmem clock.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request.
- p0_wren  in  1  port 0 write (1) / read (0).
- p0_lock  in  1  port 0 requests to keep the grant next cycle.
- p0_addr  in  ADDR_W  port 0 address.
- p0_data  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle.
- p0_rvalid  out  1  p0_q holds read data for port 0.
- p0_q  out  DATA_W  read data for port 0.
- p1_req, p1_wren, p1_lock, p1_addr, p1_data, p1_gnt, p1_rvalid, p1_q: same as port 0, for port 1.
- mem_address  out  ADDR_W  to dmem address.
- mem_data  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem wren.
- mem_q  in  DATA_W  from dmem q.

Behaviour:
- Reset (reset=0, asynchronous):
  - priority pointer = port 0; lock owner = none; lock counter = 0.
  - read-tag pipeline cleared.
  - all gnt and rvalid = 0; p0_q, p1_q = 0; mem_wren = 0.
- Grant decision is combinational in the current cycle. An access is accepted at the rising edge where req=1 and gnt=1. At most one gnt is high per cycle.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port named by the priority pointer is granted.
  - After each accepted access, the pointer moves to the other port, unless the lock rule applies.
- Lock rule:
  - If the granted port has lock=1 at acceptance, the pointer stays on that port.
  - The lock counter increments only on cycles where the other port has req=1.
  - When the counter reaches MAX_LOCK, the pointer is forced to the other port and the counter clears.
  - The counter also clears when the owner drops lock or req, or when the grant changes port.
- Memory side:
  - mem_address, mem_data and mem_wren are muxed from the granted port.
  - With no grant: mem_wren = 0, mem_address and mem_data hold their last value.
  - A write completes on acceptance; there is no response.
- Read return:
  - Each accepted read pushes a tag {valid, port} into a READ_LAT-deep shift register.
  - When the tag exits, the target port gets rvalid = 1 for exactly one cycle, with q = mem_q.
  - The non-target port's q holds its previous value and its rvalid = 0.
- Latency: a read accepted at edge N returns rvalid in the cycle after edge N+READ_LAT.
- Throughput: one access per cycle; reads are returned in issue order.
- Read-after-write to the same address on consecutive cycles returns the new data (dmem write-first is relied on; the arbiter adds no bypass).
- Both requests with wren=1 on the same cycle: only the granted write reaches memory. The loser must hold req until granted.
- Reset asserted mid-read: the in-flight tags are discarded and no rvalid is produced after reset releases.

Test Plan:
1. Reset then port 0 read: p0 addr 0x010 (mem holds 0xDEADBEEF) -> p0_gnt=1 that cycle; p0_rvalid=1, p0_q=0xDEADBEEF after READ_LAT cycles; p1_rvalid stays 0.
2. Port 1 writes 0x12345678 to 0x020, then port 0 reads 0x020 next cycle -> p0_q=0x12345678.
3. Both ports request reads continuously, no lock -> grants alternate 0,1,0,1; each rvalid goes to the correct port in issue order.
4. Port 1 holds req+lock for 20 cycles while port 0 requests -> port 1 gets exactly 8 consecutive grants, then port 0 one grant, then port 1 resumes.
5. Reset pulsed low while a read is in flight -> after reset releases, no rvalid appears; pointer=port 0; mem_wren=0.
6. Single requester with lock=1 and the other idle -> granted every cycle indefinitely; lock counter stays 0.
